// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and write-decode helper for the register file
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // One-hot write enables; bit 0 is never set because x0 has no storage.
  function automatic logic [REG_COUNT-1:0] decode_we(input logic en,
                                                     input logic [REG_ADDR_W-1:0] addr);
    decode_we = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      decode_we[i] = en & (addr == REG_ADDR_W'(i));
    end
  endfunction

endpackage

// File: rtl/mux_32_1.sv
// rtl/mux_32_1.sv - 32:1 N-bit selector used for each register-file read port
module mux_32_1 #(
  parameter int N = 32
) (
  input  logic [N-1:0] in_0,  input  logic [N-1:0] in_1,  input  logic [N-1:0] in_2,
  input  logic [N-1:0] in_3,  input  logic [N-1:0] in_4,  input  logic [N-1:0] in_5,
  input  logic [N-1:0] in_6,  input  logic [N-1:0] in_7,  input  logic [N-1:0] in_8,
  input  logic [N-1:0] in_9,  input  logic [N-1:0] in_10, input  logic [N-1:0] in_11,
  input  logic [N-1:0] in_12, input  logic [N-1:0] in_13, input  logic [N-1:0] in_14,
  input  logic [N-1:0] in_15, input  logic [N-1:0] in_16, input  logic [N-1:0] in_17,
  input  logic [N-1:0] in_18, input  logic [N-1:0] in_19, input  logic [N-1:0] in_20,
  input  logic [N-1:0] in_21, input  logic [N-1:0] in_22, input  logic [N-1:0] in_23,
  input  logic [N-1:0] in_24, input  logic [N-1:0] in_25, input  logic [N-1:0] in_26,
  input  logic [N-1:0] in_27, input  logic [N-1:0] in_28, input  logic [N-1:0] in_29,
  input  logic [N-1:0] in_30, input  logic [N-1:0] in_31,
  input  logic [4:0]   s,
  output logic [N-1:0] y
);

  logic [N-1:0] ins [32];

  assign ins = '{in_0,  in_1,  in_2,  in_3,  in_4,  in_5,  in_6,  in_7,
                 in_8,  in_9,  in_10, in_11, in_12, in_13, in_14, in_15,
                 in_16, in_17, in_18, in_19, in_20, in_21, in_22, in_23,
                 in_24, in_25, in_26, in_27, in_28, in_29, in_30, in_31};

  assign y = ins[s];

endmodule

// File: rtl/register_n.sv
// rtl/register_n.sv - N-bit enabled flop with asynchronous active-high clear
module register_n #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  assign q_d = en_i ? d_i : q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x N integer register file, one write port, two combinational read ports
module register_file
  import regfile_pkg::*;
#(
  parameter int N      = 32,
  parameter int BYPASS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_ena,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]          wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr0,
  output logic [N-1:0]          rd_data0,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  output logic [N-1:0]          rd_data1
);

  logic [REG_COUNT-1:0] we;
  logic [N-1:0]         xr [REG_COUNT];
  logic [N-1:0]         mux_out0;
  logic [N-1:0]         mux_out1;

  assign we    = decode_we(wr_ena, wr_addr);
  assign xr[0] = '0;

  for (genvar g = 1; g < REG_COUNT; g++) begin : g_reg
    register_n #(.N(N)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (we[g]),
      .d_i  (wr_data),
      .q_o  (xr[g])
    );
  end

  mux_32_1 #(.N(N)) u_mux0 (
    .in_0 (xr[0]),  .in_1 (xr[1]),  .in_2 (xr[2]),  .in_3 (xr[3]),
    .in_4 (xr[4]),  .in_5 (xr[5]),  .in_6 (xr[6]),  .in_7 (xr[7]),
    .in_8 (xr[8]),  .in_9 (xr[9]),  .in_10(xr[10]), .in_11(xr[11]),
    .in_12(xr[12]), .in_13(xr[13]), .in_14(xr[14]), .in_15(xr[15]),
    .in_16(xr[16]), .in_17(xr[17]), .in_18(xr[18]), .in_19(xr[19]),
    .in_20(xr[20]), .in_21(xr[21]), .in_22(xr[22]), .in_23(xr[23]),
    .in_24(xr[24]), .in_25(xr[25]), .in_26(xr[26]), .in_27(xr[27]),
    .in_28(xr[28]), .in_29(xr[29]), .in_30(xr[30]), .in_31(xr[31]),
    .s    (rd_addr0),
    .y    (mux_out0)
  );

  mux_32_1 #(.N(N)) u_mux1 (
    .in_0 (xr[0]),  .in_1 (xr[1]),  .in_2 (xr[2]),  .in_3 (xr[3]),
    .in_4 (xr[4]),  .in_5 (xr[5]),  .in_6 (xr[6]),  .in_7 (xr[7]),
    .in_8 (xr[8]),  .in_9 (xr[9]),  .in_10(xr[10]), .in_11(xr[11]),
    .in_12(xr[12]), .in_13(xr[13]), .in_14(xr[14]), .in_15(xr[15]),
    .in_16(xr[16]), .in_17(xr[17]), .in_18(xr[18]), .in_19(xr[19]),
    .in_20(xr[20]), .in_21(xr[21]), .in_22(xr[22]), .in_23(xr[23]),
    .in_24(xr[24]), .in_25(xr[25]), .in_26(xr[26]), .in_27(xr[27]),
    .in_28(xr[28]), .in_29(xr[29]), .in_30(xr[30]), .in_31(xr[31]),
    .s    (rd_addr1),
    .y    (mux_out1)
  );

  // Forwarding is suppressed during reset and for x0 so both stay reading zero.
  if (BYPASS != 0) begin : g_fwd
    assign rd_data0 = (!rst && wr_ena && (wr_addr == rd_addr0) && (rd_addr0 != ZERO_REG))
                      ? wr_data : mux_out0;
    assign rd_data1 = (!rst && wr_ena && (wr_addr == rd_addr1) && (rd_addr1 != ZERO_REG))
                      ? wr_data : mux_out1;
  end else begin : g_nofwd
    assign rd_data0 = mux_out0;
    assign rd_data1 = mux_out1;
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized model-checked bench for register_file, both BYPASS settings
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  bit          run_clk = 1'b1;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [31:0] nb_rd0, nb_rd1, bp_rd0, bp_rd1;

  logic [31:0] mdl [32];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pos = 0;
  bit          chk_on = 1'b0;

  register_file #(.N(32), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(nb_rd0), .rd_addr1(rd_addr1), .rd_data1(nb_rd1)
  );

  register_file #(.N(32), .BYPASS(1)) u_bp (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(bp_rd0), .rd_addr1(rd_addr1), .rd_data1(bp_rd1)
  );

  always #5 if (run_clk) clk = ~clk;
  always @(posedge clk) n_pos++;

  function automatic logic [31:0] exp_rd(bit byp, logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (byp && wr_ena && wr_addr == a) return wr_data;
    return mdl[a];
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @%0t: got %08h expected %08h", nm, $time, act, expv);
    end
  endtask

  task automatic check_all(string nm);
    check({nm, "_nb0"}, nb_rd0, exp_rd(1'b0, rd_addr0));
    check({nm, "_nb1"}, nb_rd1, exp_rd(1'b0, rd_addr1));
    check({nm, "_bp0"}, bp_rd0, exp_rd(1'b1, rd_addr0));
    check({nm, "_bp1"}, bp_rd1, exp_rd(1'b1, rd_addr1));
  endtask

  always @(negedge clk) if (chk_on) check_all("cycle");

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  // Advance one posedge; the model takes the write only if rst was low at the edge.
  task automatic do_cycle();
    @(posedge clk);
    if (!rst && wr_ena && wr_addr != 5'd0) mdl[wr_addr] = wr_data;
    #1;
  endtask

  task automatic do_write(logic [4:0] a, logic [31:0] d);
    wr_ena = 1'b1; wr_addr = a; wr_data = d;
    do_cycle();
    wr_ena = 1'b0;
  endtask

  task automatic sweep(string nm);
    for (int a = 0; a < 32; a++) begin
      rd_addr0 = 5'(a);
      rd_addr1 = 5'(31 - a);
      #1;
      check_all(nm);
    end
  endtask

  initial begin
    int n0;
    wr_ena = 1'b0; wr_addr = '0; wr_data = '0; rd_addr0 = '0; rd_addr1 = '0;
    clear_model();

    #1 rst = 1'b1;
    #1;
    check("reset_lit_nb", nb_rd0, 32'h0);
    check("reset_lit_bp", bp_rd1, 32'h0);
    @(negedge clk); #2 rst = 1'b0;
    chk_on = 1'b1;

    // Basic writes
    do_write(5'd5, 32'hDEADBEEF);
    do_write(5'd31, 32'h12345678);
    rd_addr0 = 5'd5; rd_addr1 = 5'd31; #1;
    check("x5_lit", nb_rd0, 32'hDEADBEEF);
    check("x31_lit", bp_rd1, 32'h12345678);
    sweep("sweep_basic");

    // x0 write discarded
    do_write(5'd0, 32'hFFFFFFFF);
    rd_addr0 = 5'd0; rd_addr1 = 5'd0; #1;
    check("x0_lit_nb", nb_rd0, 32'h0);
    check("x0_lit_bp", bp_rd1, 32'h0);
    sweep("sweep_x0");

    // Same-cycle read/write to x7
    do_write(5'd7, 32'h00000001);
    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr0 = 5'd7; rd_addr1 = 5'd0; #1;
    check("x7_pre_nb", nb_rd0, 32'h00000001);
    check("x7_pre_bp", bp_rd0, 32'hA5A5A5A5);
    check("x7_pre_bp_x0", bp_rd1, 32'h0);
    do_cycle();
    wr_ena = 1'b0; #1;
    check("x7_post_nb", nb_rd0, 32'hA5A5A5A5);

    // Both ports on x12, then disabled write is ignored
    do_write(5'd12, 32'h0BADF00D);
    rd_addr0 = 5'd12; rd_addr1 = 5'd12;
    wr_ena = 1'b0; wr_addr = 5'd12; wr_data = 32'h0;
    do_cycle();
    check("x12_p0", nb_rd0, 32'h0BADF00D);
    check("x12_p1", nb_rd1, 32'h0BADF00D);
    check("x12_bp", bp_rd0, 32'h0BADF00D);

    // Randomized traffic with occasional mid-cycle reset pulses
    for (int i = 0; i < 400; i++) begin
      wr_ena  = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      rd_addr1 = ($urandom_range(0, 3) == 0) ? rd_addr0 : 5'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b1;
        clear_model();
        #1 check_all("rand_rst");
        rst = 1'b0;
      end
      do_cycle();
    end

    // Asynchronous reset with the clock stopped, over arbitrary contents
    wr_ena = 1'b0;
    @(negedge clk); run_clk = 1'b0; #1;
    n0 = n_pos;
    rst = 1'b1;
    clear_model();
    sweep("sweep_rst_noclk");
    rd_addr0 = 5'd5; rd_addr1 = 5'd12; #1;
    check("rst_noclk_lit", nb_rd0, 32'h0);
    check("rst_noclk_edges", 32'(n_pos), 32'(n0));
    rst = 1'b0; run_clk = 1'b1;

    // Reset in the middle of a write stream, then resume
    for (int i = 0; i < 6; i++) begin
      wr_ena = 1'b1; wr_addr = 5'(i + 20); wr_data = 32'hC0DE0000 + 32'(i);
      if (i == 3) begin
        rd_addr0 = 5'd20; rd_addr1 = 5'd21;
        n0 = n_pos;
        #2 rst = 1'b1;
        clear_model();
        #1;
        check("stream_rst_p0", nb_rd0, 32'h0);
        check("stream_rst_p1", bp_rd1, 32'h0);
        check("stream_rst_bp_fwd", bp_rd0, 32'h0);
        check("stream_rst_edges", 32'(n_pos), 32'(n0));
        rst = 1'b0;
      end
      do_cycle();
    end
    wr_ena = 1'b0; rd_addr0 = 5'd23; rd_addr1 = 5'd20; #1;
    check("stream_resume", nb_rd0, 32'hC0DE0003);
    check("stream_cleared", nb_rd1, 32'h0);
    sweep("sweep_end");

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
